// File: rtl/aes_keyslot_ctrl.sv
// aes_keyslot_ctrl
//   START/ZEROIZE command controller in front of an aes1_core-compatible core,
//   with a bank of NUM_KEY_SLOTS 256-bit key slots. Key expansion is skipped
//   when the selected slot was the last one expanded and has not been written
//   since.
//
// Optional feature macro: AES_KEYSLOT_IRQ_EN
//   defined   : IRQ_EN register (bit0 done, bit1 err) and registered irq_o
//   undefined : IRQ_EN reads 0 / ignores writes, irq_o tied 0
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset (shared with core)
//   reglk_ctrl_i[7:0]        lock bits (0 name rd, 1 CTRL/CONFIG wr, 3 key wr,
//                            4 STATUS/RESULT rd, 5 BLOCK/KEY_SEL wr)
//   acct_ctrl_i, debug_mode_i access permit / debug (blanks key, rejects START)
//   en_i, we_i, addr_i, wdata_i, rdata_o   register port, word = addr_i[11:3]
//   core_*_o / core_*_i      aes core handshake, key, block and result
//   irq_o                    level interrupt
//
// Word ordering: the lowest word index of a multi-word field holds its most
// significant 32 bits (KEY[s][0] = key[255:224], BLOCK 0x40 = block[127:96],
// RESULT 0x50 = result[127:96]).

// One key slot: eight key words, keylen bit and the "written since last
// expansion" flag.
module aes_keyslot_slot (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_key_we,
  input  logic [2:0]   i_key_wi,
  input  logic         i_klen_we,
  input  logic [31:0]  i_wdata,
  input  logic         i_z_we,
  input  logic [2:0]   i_z_wi,
  input  logic         i_z_start,
  input  logic         i_fresh_clr,
  output logic [255:0] o_key,
  output logic         o_keylen,
  output logic         o_fresh
);
  logic [0:7][31:0] r_key;
  logic             r_klen;
  logic             r_fresh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key   <= '0;
      r_klen  <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      if (i_z_we)        r_key[i_z_wi]   <= '0;
      else if (i_key_we) r_key[i_key_wi] <= i_wdata;
      if (i_z_start)      r_klen <= 1'b0;
      else if (i_klen_we) r_klen <= i_wdata[0];
      // a write racing the end of an expansion keeps the slot dirty
      if (i_key_we | i_klen_we)         r_fresh <= 1'b1;
      else if (i_fresh_clr | i_z_start) r_fresh <= 1'b0;
    end
  end

  assign o_key    = r_key;
  assign o_keylen = r_klen;
  assign o_fresh  = r_fresh;
endmodule

module aes_keyslot_ctrl #(
  parameter int NUM_KEY_SLOTS = 3,
  parameter int SLOT_W        = (NUM_KEY_SLOTS > 1) ? $clog2(NUM_KEY_SLOTS) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [7:0]   reglk_ctrl_i,
  input  logic         acct_ctrl_i,
  input  logic         debug_mode_i,
  input  logic         en_i,
  input  logic         we_i,
  input  logic [11:0]  addr_i,
  input  logic [63:0]  wdata_i,
  output logic [63:0]  rdata_o,
  output logic         core_init_o,
  output logic         core_next_o,
  output logic         core_encdec_o,
  output logic         core_keylen_o,
  output logic [255:0] core_key_o,
  output logic [127:0] core_block_o,
  input  logic         core_ready_i,
  input  logic         core_valid_i,
  input  logic [127:0] core_result_i,
  output logic         irq_o
);
  localparam int NSLOT_P = 1 << SLOT_W;
  localparam int ZW      = SLOT_W + 3;
  localparam logic [ZW-1:0] ZLAST = ZW'(8 * NUM_KEY_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_INIT_GAP = 3'd2,
    S_WAIT_KEY = 3'd3,
    S_NEXT     = 3'd4,
    S_NEXT_GAP = 3'd5,
    S_WAIT_RES = 3'd6,
    S_ZERO     = 3'd7
  } state_e;

  state_e r_state, w_state_nx;

  logic              r_encdec;
  logic [SLOT_W-1:0] r_key_sel;
  logic [0:3][31:0]  r_block;
  logic [0:3][31:0]  r_result;
  logic [SLOT_W-1:0] r_op_slot;
  logic              r_op_keylen;
  logic              r_op_encdec;
  logic [255:0]      r_op_key;
  logic [127:0]      r_op_block;
  logic              r_done, r_err;
  logic              r_exp_vld;
  logic [SLOT_W-1:0] r_exp_slot;
  logic [ZW-1:0]     r_zcnt;

  logic [NSLOT_P-1:0][255:0] w_slot_key;
  logic [NSLOT_P-1:0]        w_slot_klen;
  logic [NSLOT_P-1:0]        w_fresh;

  logic        w_acc, w_wr;
  logic [8:0]  w_idx;
  logic [31:0] w_wd;
  logic        w_ctrl_hit, w_ctrl_ok, w_start_req, w_zero_req, w_clr;
  logic        w_idle, w_slot_ok, w_start_ok, w_start_err, w_zero_go;
  logic        w_exp_done, w_res_done, w_need_init, w_key_lock;
  logic        w_init, w_next;
  logic [63:0] w_rdata;
  logic        w_unused;

  assign w_acc = en_i & acct_ctrl_i;
  assign w_wr  = w_acc & we_i;
  assign w_idx = addr_i[11:3];
  assign w_wd  = wdata_i[31:0];

  // CTRL decode; a locked CTRL still sees START so it can be flagged as err
  assign w_ctrl_hit  = w_wr & (w_idx == 9'h008);
  assign w_ctrl_ok   = w_ctrl_hit & ~reglk_ctrl_i[1];
  assign w_start_req = w_ctrl_hit & w_wd[0];
  assign w_zero_req  = w_ctrl_ok & w_wd[1];
  assign w_clr       = w_ctrl_ok & w_wd[2];
  assign w_idle      = (r_state == S_IDLE);
  assign w_slot_ok   = (32'(r_key_sel) < 32'(NUM_KEY_SLOTS));
  // ZEROIZE wins over a START written in the same access
  assign w_start_ok  = w_ctrl_ok & w_wd[0] & w_idle & ~w_zero_req &
                       ~debug_mode_i & w_slot_ok;
  assign w_start_err = w_start_req & ~w_start_ok;
  assign w_zero_go   = w_zero_req & w_idle;
  assign w_exp_done  = (r_state == S_WAIT_KEY) & core_ready_i;
  assign w_res_done  = (r_state == S_WAIT_RES) & core_ready_i & core_valid_i;
  assign w_need_init = w_fresh[r_key_sel] | ~r_exp_vld | (r_key_sel != r_exp_slot);
  assign w_key_lock  = reglk_ctrl_i[3] | (r_state == S_ZERO);

  // key slot bank; slot indices past NUM_KEY_SLOTS read as empty
  for (genvar g = 0; g < NSLOT_P; g++) begin : g_slot
    if (g < NUM_KEY_SLOTS) begin : g_real
      logic w_kwe, w_lwe, w_zwe, w_fclr;
      assign w_kwe  = w_wr & ~w_key_lock & (w_idx[8:7] == 2'b01) & (w_idx[6:3] == 4'(g));
      assign w_lwe  = w_wr & ~w_key_lock & (w_idx[8:3] == 6'h0c) & (w_idx[2:0] == 3'(g));
      assign w_zwe  = (r_state == S_ZERO) & (r_zcnt[ZW-1:3] == SLOT_W'(g));
      assign w_fclr = w_exp_done & (r_op_slot == SLOT_W'(g));
      aes_keyslot_slot u_slot (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_key_we    (w_kwe),
        .i_key_wi    (w_idx[2:0]),
        .i_klen_we   (w_lwe),
        .i_wdata     (w_wd),
        .i_z_we      (w_zwe),
        .i_z_wi      (r_zcnt[2:0]),
        .i_z_start   (w_zero_go),
        .i_fresh_clr (w_fclr),
        .o_key       (w_slot_key[g]),
        .o_keylen    (w_slot_klen[g]),
        .o_fresh     (w_fresh[g])
      );
    end else begin : g_pad
      assign w_slot_key[g]  = '0;
      assign w_slot_klen[g] = 1'b0;
      assign w_fresh[g]     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_init     = 1'b0;
    w_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_zero_go)       w_state_nx = S_ZERO;
        else if (w_start_ok) w_state_nx = w_need_init ? S_INIT : S_NEXT;
      end
      S_INIT: begin
        w_init     = 1'b1;
        w_state_nx = S_INIT_GAP;
      end
      S_INIT_GAP: w_state_nx = S_WAIT_KEY;
      S_WAIT_KEY: if (core_ready_i) w_state_nx = S_NEXT;
      S_NEXT: begin
        w_next     = 1'b1;
        w_state_nx = S_NEXT_GAP;
      end
      S_NEXT_GAP: w_state_nx = S_WAIT_RES;
      S_WAIT_RES: if (core_ready_i & core_valid_i) w_state_nx = S_IDLE;
      S_ZERO:     if (r_zcnt == ZLAST) w_state_nx = S_IDLE;
      default:    w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_encdec    <= 1'b0;
      r_key_sel   <= '0;
      r_block     <= '0;
      r_result    <= '0;
      r_op_slot   <= '0;
      r_op_keylen <= 1'b0;
      r_op_encdec <= 1'b0;
      r_op_key    <= '0;
      r_op_block  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_exp_vld   <= 1'b0;
      r_exp_slot  <= '0;
      r_zcnt      <= '0;
    end else begin
      if (w_wr & ~reglk_ctrl_i[1] & (w_idx == 9'h00a)) r_encdec  <= w_wd[0];
      if (w_wr & ~reglk_ctrl_i[5] & (w_idx == 9'h00b)) r_key_sel <= w_wd[SLOT_W-1:0];
      if (w_zero_go) r_block <= '0;
      else if (w_wr & ~reglk_ctrl_i[5] & (w_idx[8:2] == 7'h10)) r_block[w_idx[1:0]] <= w_wd;
      if (w_zero_go)       r_result <= '0;
      else if (w_res_done) r_result <= core_result_i;
      // snapshot of everything the operation uses, so later writes cannot leak in
      if (w_start_ok) begin
        r_op_slot   <= r_key_sel;
        r_op_keylen <= w_slot_klen[r_key_sel];
        r_op_encdec <= r_encdec;
        r_op_key    <= w_slot_key[r_key_sel];
        r_op_block  <= r_block;
      end
      if (w_res_done) r_done <= 1'b1;
      else if (w_clr) r_done <= 1'b0;
      // clear is applied before a START in the same write, so a rejected START still flags
      if (w_start_err) r_err <= 1'b1;
      else if (w_clr)  r_err <= 1'b0;
      if (w_zero_go) r_exp_vld <= 1'b0;
      else if (w_exp_done) begin
        r_exp_vld  <= 1'b1;
        r_exp_slot <= r_op_slot;
      end
      if (w_zero_go)              r_zcnt <= '0;
      else if (r_state == S_ZERO) r_zcnt <= r_zcnt + ZW'(1);
    end
  end

`ifdef AES_KEYSLOT_IRQ_EN
  logic [1:0] r_irq_en;
  logic       r_irq;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_en <= 2'b00;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr & ~reglk_ctrl_i[1] & (w_idx == 9'h00c)) r_irq_en <= w_wd[1:0];
      r_irq <= (r_done & r_irq_en[0]) | (r_err & r_irq_en[1]);
    end
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    if (w_acc) begin
      case (w_idx)
        9'h000: if (!reglk_ctrl_i[0]) w_rdata[31:0] = 32'h6165_7320;
        9'h001: if (!reglk_ctrl_i[0]) w_rdata[31:0] = 32'h2020_2020;
        9'h002: if (!reglk_ctrl_i[0]) w_rdata[31:0] = 32'h312e_3030;
        9'h009: if (!reglk_ctrl_i[4])
                  w_rdata[4:0] = {(r_state == S_ZERO), r_err, r_done,
                                  ~w_idle & (r_state != S_ZERO), w_idle};
        9'h00a: w_rdata[0] = r_encdec;
        9'h00b: w_rdata[SLOT_W-1:0] = r_key_sel;
`ifdef AES_KEYSLOT_IRQ_EN
        9'h00c: w_rdata[1:0] = r_irq_en;
`endif
        9'h040, 9'h041, 9'h042, 9'h043: w_rdata[31:0] = r_block[w_idx[1:0]];
        9'h050, 9'h051, 9'h052, 9'h053:
          if (!reglk_ctrl_i[4]) w_rdata[31:0] = r_result[w_idx[1:0]];
        default: ;
      endcase
    end
  end

  assign rdata_o       = w_rdata;
  assign core_init_o   = w_init;
  assign core_next_o   = w_next;
  assign core_encdec_o = r_op_encdec;
  assign core_keylen_o = r_op_keylen;
  assign core_key_o    = debug_mode_i ? '0 : r_op_key;
  assign core_block_o  = r_op_block;

  assign w_unused = ^{wdata_i[63:32], reglk_ctrl_i[7:6], reglk_ctrl_i[2]};
endmodule

// File: tb/tb_aes_keyslot_ctrl.sv
// Directed bench for aes_keyslot_ctrl with a behavioural core model that
// returns the FIPS-197 ciphertext for the FIPS-197 key/plaintext pair and
// block ^ key[255:128] otherwise.
module tb_aes_keyslot_ctrl;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   reglk;
  logic         acct, dbg, en, we;
  logic [11:0]  addr;
  logic [63:0]  wdata, rdata;
  logic         c_init, c_next, c_encdec, c_keylen;
  logic [255:0] c_key;
  logic [127:0] c_block;
  logic         c_ready, c_valid;
  logic [127:0] c_result;
  logic         irq;

  int n_cmp = 0;
  int n_bad = 0;
  int n_init = 0;
  int n_next = 0;

  always #5 clk = ~clk;

  aes_keyslot_ctrl #(.NUM_KEY_SLOTS(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reglk_ctrl_i(reglk), .acct_ctrl_i(acct),
    .debug_mode_i(dbg), .en_i(en), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .core_init_o(c_init), .core_next_o(c_next),
    .core_encdec_o(c_encdec), .core_keylen_o(c_keylen), .core_key_o(c_key),
    .core_block_o(c_block), .core_ready_i(c_ready), .core_valid_i(c_valid),
    .core_result_i(c_result), .irq_o(irq)
  );

  // core model: init -> ready low 4 cycles; next -> ready/valid low 6 cycles
  logic [255:0] m_key;
  logic [127:0] m_blk;
  logic [3:0]   m_cnt;
  logic         m_isnext;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ready <= 1'b1; c_valid <= 1'b0; c_result <= '0; m_cnt <= '0; m_isnext <= 1'b0;
    end else if (c_init) begin
      n_init <= n_init + 1; m_key <= c_key; c_ready <= 1'b0; c_valid <= 1'b0;
      m_cnt <= 4'd4; m_isnext <= 1'b0;
    end else if (c_next) begin
      n_next <= n_next + 1; m_blk <= c_block; c_ready <= 1'b0; c_valid <= 1'b0;
      m_cnt <= 4'd6; m_isnext <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        c_ready <= 1'b1;
        if (m_isnext) begin
          c_valid  <= 1'b1;
          c_result <= (m_key[255:128] == FIPS_K && m_blk == FIPS_P) ? FIPS_C
                                                                    : (m_blk ^ m_key[255:128]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] idx, input logic [63:0] d);
    @(negedge clk); en = 1'b1; we = 1'b1; addr = {idx, 3'b000}; wdata = d;
    @(negedge clk); en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [8:0] idx, output logic [63:0] d);
    @(negedge clk); en = 1'b1; we = 1'b0; addr = {idx, 3'b000};
    #1 d = rdata; en = 1'b0;
  endtask

  task automatic rd_res(output logic [127:0] v);
    logic [63:0] r;
    for (int j = 0; j < 4; j++) begin
      rd(9'(9'h050 + j), r);
      v[127-32*j -: 32] = r[31:0];
    end
  endtask

  task automatic wait_idle(input string tag);
    logic [63:0] s;
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rd(9'h009, s);
      if (s[0]) begin ok = 1'b1; break; end
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    logic [63:0]  r;
    logic [127:0] res;
    int i0, n0, zc;
    rst_n = 1'b0; reglk = '0; acct = 1'b1; dbg = 1'b0;
    en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #12;
    chk("rst_ctl", {c_init, c_next, c_encdec, c_keylen, irq}, 0);
    chk("rst_key_hi", c_key[255:128], 0);
    chk("rst_key_lo", c_key[127:0], 0);
    chk("rst_blk", c_block, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    rd(9'h009, r); chk("rst_status", r, 64'h1);
    rd(9'h000, r); chk("name0", r, 64'h6165_7320);
    rd(9'h002, r); chk("name2", r, 64'h312e_3030);
    reglk = 8'h01; rd(9'h000, r); chk("name_locked", r, 0); reglk = '0;

    // FIPS-197 key in slot 1, 128-bit
    wr(9'h088, 64'h0001_0203); wr(9'h089, 64'h0405_0607);
    wr(9'h08a, 64'h0809_0a0b); wr(9'h08b, 64'h0c0d_0e0f);
    for (int j = 4; j < 8; j++) wr(9'(9'h088 + j), 64'h0);
    wr(9'h061, 64'h0); wr(9'h00b, 64'h1);
    wr(9'h040, 64'h0011_2233); wr(9'h041, 64'h4455_6677);
    wr(9'h042, 64'h8899_aabb); wr(9'h043, 64'hccdd_eeff);
    rd(9'h088, r); chk("key_reads_0", r, 0);
    rd(9'h061, r); chk("keylen_reads_0", r, 0);
    i0 = n_init; n0 = n_next;
    wr(9'h008, 64'h1);
    chk("init_after_start", {c_init, c_next}, 2'b10);
    wait_idle("run1_idle");
    chk("run1_inits", n_init - i0, 1);
    chk("run1_nexts", n_next - n0, 1);
    chk("run1_key", c_key[255:128], FIPS_K);
    rd_res(res); chk("run1_result", res, FIPS_C);
    rd(9'h009, r); chk("run1_status", r, 64'h5);

    // cached key: no init, next right after START
    wr(9'h00a, 64'h1); rd(9'h00a, r); chk("config_rd", r, 1);
    i0 = n_init; n0 = n_next;
    wr(9'h008, 64'h1);
    chk("next_after_start", {c_init, c_next}, 2'b01);
    wait_idle("run2_idle");
    chk("run2_inits", n_init - i0, 0);
    chk("run2_nexts", n_next - n0, 1);
    chk("run2_encdec", c_encdec, 1);
    rd_res(res); chk("run2_result", res, FIPS_C);

    // debug mode hides key and rejects START
    dbg = 1'b1; #1 chk("dbg_key", c_key[255:128], 0);
    n0 = n_next;
    wr(9'h008, 64'h1);
    rd(9'h009, r); chk("dbg_status", r, 64'hd);
    chk("dbg_no_next", n_next - n0, 0);
    dbg = 1'b0;
    wr(9'h008, 64'h4); rd(9'h009, r); chk("clr_status", r, 64'h1);

    // START while busy
    wr(9'h008, 64'h1); wr(9'h008, 64'h1);
    wait_idle("busy_idle");
    rd(9'h009, r); chk("busy_status", r, 64'hd);
    rd_res(res); chk("busy_result", res, FIPS_C);
    // CLR_DONE together with START: clear first, then run
    wr(9'h008, 64'h5);
    wait_idle("clrstart_idle");
    rd(9'h009, r); chk("clrstart_status", r, 64'h5);

    // expand slot 0, then a locked key write must leave it cached
    wr(9'h00b, 64'h0); i0 = n_init;
    wr(9'h008, 64'h1); wait_idle("slot0_idle");
    chk("slot0_inits", n_init - i0, 1);
    reglk = 8'h08; wr(9'h080, 64'hdead_beef); reglk = '0;
    i0 = n_init;
    wr(9'h008, 64'h1); wait_idle("lock_idle");
    chk("lock_no_init", n_init - i0, 0);
    chk("lock_key", c_key[255:224], 0);
    reglk = 8'h10;
    rd(9'h050, r); chk("res_locked", r, 0);
    rd(9'h009, r); chk("status_locked", r, 0);
    reglk = '0;
    rd(9'h050, r); chk("res_unlocked", r, 64'h0011_2233);

    // ZEROIZE
    wr(9'h00b, 64'h1);
    wr(9'h008, 64'h2);
    en = 1'b1; we = 1'b0; addr = {9'h009, 3'b000}; zc = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (rdata[4]) zc++; else break;
      @(negedge clk);
    end
    en = 1'b0;
    chk("zero_cycles", zc, 24);
    rd_res(res); chk("zero_result", res, 0);
    rd(9'h040, r); chk("zero_block", r, 0);
    wr(9'h043, 64'h1234);
    i0 = n_init;
    wr(9'h008, 64'h1); wait_idle("zrun_idle");
    chk("zrun_inits", n_init - i0, 1);
    chk("zrun_key_hi", c_key[255:128], 0);
    chk("zrun_key_lo", c_key[127:0], 0);
    rd_res(res); chk("zrun_result", res, 128'h1234);

    // reset during WAIT_RES
    wr(9'h008, 64'h1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {c_init, c_next, c_encdec, c_keylen, irq}, 0);
    chk("mid_rst_key", c_key[255:128] | c_key[127:0], 0);
    chk("mid_rst_blk", c_block, 0);
    chk("mid_rst_rdata", rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    rd(9'h009, r); chk("post_rst_status", r, 64'h1);
    i0 = n_init;
    wr(9'h008, 64'h1); wait_idle("post_rst_idle");
    chk("post_rst_inits", n_init - i0, 1);

    wr(9'h00c, 64'h3); rd(9'h00c, r);
`ifdef AES_KEYSLOT_IRQ_EN
    chk("irq_en_rd", r, 64'h3);
`else
    chk("irq_en_rd", r, 0);
    chk("irq_tied", irq, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_keyslot_ctrl.md
# aes_keyslot_ctrl

Parametrised AES command controller with a bank of key slots. It sits between the `axi_lite_interface` register port and an `aes1_core`-compatible core inside the next-generation AES wrapper. It replaces level-sensitive init/next register pokes with a single START command. A sequencing FSM then performs key expansion and block processing, captures the result, and raises a sticky DONE and an optional interrupt. Key expansion is skipped when the selected slot is unchanged since its last expansion, and a ZEROIZE command wipes every slot.

## Interface
- `NUM_KEY_SLOTS`, 3, number of 256-bit key slots (1..8).
- `SLOT_W`, `$clog2(NUM_KEY_SLOTS)` (min 1), key-select width (derived).
- `clk_i` in 1 — clock.
- `rst_ni` in 1 — one clock; reset is asynchronous and active-low.
- `reglk_ctrl_i` in 8 — lock bits:
  - [0] blanks name/version reads.
  - [1] locks CTRL/CONFIG writes.
  - [3] locks key and keylen writes.
  - [4] blanks STATUS/RESULT reads.
  - [5] locks BLOCK/KEY_SEL writes.
- `acct_ctrl_i` in 1 — access permit, ANDed with `en_i`.
- `debug_mode_i` in 1 — forces `core_key_o` to 0 and rejects START.
- `en_i`, `we_i` in 1 — register access strobe / write.
- `addr_i` in 12 — byte address; word index = `addr_i[11:3]`.
- `wdata_i` in 64, `rdata_o` out 64 — write/read data. Read is combinational; 0 when not enabled.
- `core_init_o`, `core_next_o` out 1 — single-cycle pulses.
- `core_encdec_o`, `core_keylen_o` out 1; `core_key_o` out 256; `core_block_o` out 128.
- `core_ready_i`, `core_valid_i` in 1; `core_result_i` in 128.
- `irq_o` out 1 — level interrupt (see Configuration).

## Operation
- Word map:
  - 0x00–0x02 name/version (`"aes "`, `"    "`, `"1.00"`).
  - 0x08 CTRL (W1 pulse): bit0 START, bit1 ZEROIZE, bit2 CLR_DONE.
  - 0x09 STATUS (RO): bit0 idle, bit1 busy, bit2 done, bit3 err, bit4 zeroizing.
  - 0x0a CONFIG: bit0 encdec.
  - 0x0b KEY_SEL.
  - 0x0c IRQ_EN.
  - 0x40–0x43 BLOCK.
  - 0x50–0x53 RESULT (RO, captured copy).
  - 0x60+s KEYLEN[s].
  - 0x80+8s+w KEY[s][w], w = 0..7, lower 32 bits used.
- Key words and KEYLEN always read 0. Unmapped indices and slots ≥ `NUM_KEY_SLOTS` read 0 and ignore writes.
- Per-slot `fresh` flag: set by any write to the slot's key words or KEYLEN. Cleared when that slot's expansion completes.
- FSM states: IDLE, INIT, INIT_GAP, WAIT_KEY, NEXT, NEXT_GAP, WAIT_RES, ZERO.
  - IDLE, START accepted → INIT if `fresh[key_sel]`, or if `key_sel` ≠ last expanded slot, or if no slot has been expanded since reset or ZEROIZE. Otherwise → NEXT.
  - INIT: `core_init_o` = 1 for one cycle → INIT_GAP (one cycle) → WAIT_KEY.
  - WAIT_KEY: stay until `core_ready_i` = 1 → NEXT.
  - NEXT: `core_next_o` = 1 for one cycle → NEXT_GAP (one cycle) → WAIT_RES.
  - WAIT_RES: stay until `core_ready_i` && `core_valid_i`; then capture RESULT, set done → IDLE.
- START is rejected, and err is set, when the FSM is not IDLE, when `debug_mode_i` = 1, or when CTRL is locked.
- Slot, keylen, encdec and block are latched at START. Register writes during busy never affect the running operation.
- ZEROIZE, accepted only in IDLE:
  - Enters ZERO; a counter clears one key word per cycle, 8·`NUM_KEY_SLOTS` cycles total.
  - Also clears KEYLENs, BLOCK, RESULT and the expanded-slot record, then returns to IDLE.
  - Key writes during ZERO are dropped.
- CLR_DONE clears done and err. If START and CLR_DONE are written together, clear applies first, then START.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - All registers 0.
  - All `fresh` flags 0; no slot expanded.
- Register writes update on the clock edge after the accepted access.
- `core_init_o` or `core_next_o` asserts on the cycle after START is accepted.
- Cached-key latency: START → done = 3 + core block latency.
- Reset asserted mid-operation: immediate return to IDLE, all state cleared. The core shares `rst_ni`.

## Configuration
- `AES_KEYSLOT_IRQ_EN` defined:
  - IRQ_EN bit0 is implemented.
  - `irq_o` = done & IRQ_EN[0], registered.
  - err also drives `irq_o` when IRQ_EN[1] is set.
- Not defined: IRQ_EN reads 0 and ignores writes; `irq_o` tied 0.

## Test plan
- Write KEY[1] with a FIPS-197 128-bit key, KEYLEN[1] = 0, KEY_SEL = 1, BLOCK = 00112233…ff, START → one `core_init_o` and one `core_next_o`; RESULT = 69c4e0d86a7b0430d8cdb78070b4c55a; STATUS = 0x5.
- Repeat START with no key change → no `core_init_o`; exactly one `core_next_o`; same RESULT.
- START while busy → STATUS.err = 1; the running operation still completes unaffected.
- ZEROIZE with `NUM_KEY_SLOTS` = 3 → STATUS.zeroizing high for 24 cycles; the following START re-expands an all-zero key.
- `reglk_ctrl_i[3]` = 1, write KEY[0] → key unchanged and `fresh[0]` stays 0. `reglk_ctrl_i[4]` = 1 → RESULT reads 0.
- Assert `rst_ni` low during WAIT_RES → all outputs 0 immediately; `irq_o` = 0; STATUS = 0x1 after release.
